fpu_addsub_sequencer: RTL
=========================

FPU_ADDSUB_SEQUENCER -- requirements
Module: fpu_addsub_sequencer

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 32, operand/result width (IEEE-754 single).
- RSLT_DLY, 5, fixed latency of the attached add/sub unit, in cycles.
- DEPTH, 8, result FIFO entries (power of two, >=2).
- TAG_BITS, 4, request tag width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous reset, active-high.
- req_valid, in, 1, request present.
- req_ready, out, 1, request can be accepted.
- req_a, in, WIDTH, operand a.
- req_b, in, WIDTH, operand b.
- req_op, in, 1, 0 = add, 1 = sub.
- req_tag, in, TAG_BITS, opaque ID returned with the result.
- fpu_a, out, WIDTH, operand a to the add/sub unit.
- fpu_b, out, WIDTH, operand b to the add/sub unit.
- fpu_op, out, 1, operation_select to the add/sub unit.
- fpu_r, in, WIDTH, result R from the unit, valid RSLT_DLY cycles after operand capture.
- rsp_valid, out, 1, result available.
- rsp_ready, in, 1, consumer accepts result.
- rsp_r, out, WIDTH, result.
- rsp_tag, out, TAG_BITS, tag of the originating request.
- rsp_flags, out, 4, {nan, inf, zero, sign} classification of rsp_r.

REQ-003 One clock and one synchronous active-high reset SHALL be used. There SHALL be no asynchronous logic.

Function
REQ-004 A request SHALL be accepted on a rising edge when req_valid && req_ready.
REQ-005 fpu_a, fpu_b and fpu_op SHALL be combinational copies of req_a, req_b and req_op every cycle. The unit samples them on the acceptance edge.
REQ-006 An in-flight shadow shift register of RSLT_DLY stages SHALL carry {valid, tag}. Stage 0 loads {1, req_tag} on accept and {0, x} otherwise.
REQ-007 When the last shadow stage is valid, fpu_r and its tag SHALL be written into the FIFO on that edge. This edge is exactly RSLT_DLY edges after acceptance.
REQ-008 The FIFO SHALL be first-in first-out. Results SHALL return in acceptance order, with no reordering and no drops.
REQ-009 rsp_valid SHALL be high exactly when the FIFO is non-empty. rsp_r, rsp_tag and rsp_flags SHALL present the head entry.
REQ-010 The head entry SHALL be popped on an edge with rsp_valid && rsp_ready.
REQ-011 While rsp_valid is high and unpopped, rsp_r, rsp_tag and rsp_flags SHALL remain stable.
REQ-012 Credits SHALL be held in a counter of width clog2(DEPTH)+1, initialised to DEPTH:
- accept only: decrement;
- pop only: increment;
- accept and pop on the same edge: unchanged.
REQ-013 req_ready SHALL equal (credits != 0). This guarantees in-flight + occupancy <= DEPTH, so a FIFO write never meets a full FIFO.
REQ-014 A FIFO write and a FIFO pop on the same edge SHALL both take effect. This includes write into an empty FIFO with a simultaneous pop of nothing: the write stands and no underflow occurs.
REQ-015 Read and write pointers SHALL wrap modulo DEPTH. Full and empty SHALL be distinguished by an extra pointer bit or an occupancy count.
REQ-016 rsp_flags SHALL be derived combinationally from the head rsp_r:
- nan = exp==8'hFF && mant!=0;
- inf = exp==8'hFF && mant==0;
- zero = rsp_r[30:0]==0;
- sign = rsp_r[31].
REQ-017 Minimum request-to-rsp_valid latency SHALL be RSLT_DLY+1 cycles. Sustained throughput SHALL be one request per cycle while rsp_ready is high.
REQ-018 The block SHALL NOT modify, round or reclassify fpu_r. The data path is pass-through.

Reset
REQ-019 While rst is high at an edge, the following SHALL hold:
- shadow valids cleared;
- FIFO pointers/occupancy cleared;
- credits = DEPTH.
REQ-020 After reset, rsp_valid SHALL be 0, req_ready SHALL be 1 and rsp_flags SHALL be 0. rsp_r and rsp_tag SHALL be 0 when empty.
REQ-021 Reset mid-operation SHALL discard every in-flight and buffered result. Unit outputs arriving after reset for pre-reset requests SHALL never be written, because their shadow valid is cleared.
REQ-022 A request presented in the same cycle rst is high SHALL NOT be accepted.

Verification
REQ-023 Single add: req_a=0x3F800000, req_b=0x40000000, req_op=0, tag=3 accepted at edge E0, rsp_ready=1 -> rsp_valid rises after edge E5, rsp_r=0x40400000, rsp_tag=3, rsp_flags=0000.
REQ-024 Backpressure: rsp_ready=0, req_valid held high with tags 0..9 -> exactly 8 accepts, then req_ready=0. Raising rsp_ready -> tags 0..7 returned in order, with req_ready reasserting one cycle per pop.
REQ-025 Simultaneous accept+pop at credits=0 is impossible. At credits=1, accept+pop on the same edge -> credits stays 1 and req_ready stays 1.
REQ-026 NaN: req_a=0x7FC00001, req_b=0x3F800000 -> rsp_r=0x7FC00000, rsp_flags=1000. Sub of 0xFF800000 and 0x7F800000 -> rsp_r=0xFF800000, rsp_flags=0101.
REQ-027 Zero: +0 + -0 (0x00000000, 0x80000000, op=0) -> rsp_r=0x00000000, rsp_flags=0010.
REQ-028 Reset mid-flight: accept 3 requests, assert rst for 1 cycle two edges later -> rsp_valid stays 0 for at least 10 cycles, and credits=8 (8 further accepts possible with rsp_ready=0).

Source files
------------

// File: rtl/fpu_addsub_sequencer.sv
// Request sequencer for a fixed-latency FP add/sub unit. A shadow pipe carries tags alongside
// the unit, and results return in order through a FIFO whose space is reserved by credits.
module fpu_addsub_sequencer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned RSLT_DLY = 5,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TAG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [WIDTH-1:0]    req_a,
  input  logic [WIDTH-1:0]    req_b,
  input  logic                req_op,
  input  logic [TAG_BITS-1:0] req_tag,
  output logic [WIDTH-1:0]    fpu_a,
  output logic [WIDTH-1:0]    fpu_b,
  output logic                fpu_op,
  input  logic [WIDTH-1:0]    fpu_r,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_r,
  output logic [TAG_BITS-1:0] rsp_tag,
  output logic [3:0]          rsp_flags
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned PtrBits = PtrW + 1;
  localparam int unsigned CredW   = $clog2(DEPTH) + 1;
  localparam int unsigned ShTagW  = RSLT_DLY * TAG_BITS;

  logic                accept;
  logic                pop;
  logic                fifo_wr;
  logic                fifo_empty;

  logic [RSLT_DLY-1:0] sh_valid_q, sh_valid_d;
  logic [ShTagW-1:0]   sh_tag_q, sh_tag_d;
  logic [TAG_BITS-1:0] sh_tag_last;

  logic [PtrW:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]       rd_ptr_q, rd_ptr_d;
  logic [CredW-1:0]    credits_q, credits_d;

  logic [WIDTH-1:0]    mem_r   [DEPTH];
  logic [TAG_BITS-1:0] mem_tag [DEPTH];

  logic [7:0]          head_exp;
  logic [WIDTH-10:0]   head_mant;
  logic                head_nan, head_inf, head_zero, head_sign;

  // The unit samples these on the acceptance edge, so they are plain wires.
  assign fpu_a  = req_a;
  assign fpu_b  = req_b;
  assign fpu_op = req_op;

  assign req_ready  = (credits_q != '0);
  assign accept     = req_valid && req_ready && !rst;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign rsp_valid  = !fifo_empty;
  assign pop        = rsp_valid && rsp_ready;

  assign fifo_wr     = sh_valid_q[RSLT_DLY-1];
  assign sh_tag_last = sh_tag_q[ShTagW-1 -: TAG_BITS];

  // Stage 0 sits in the low bits; the oldest stage falls off the top.
  assign sh_valid_d = RSLT_DLY'({sh_valid_q, accept});
  assign sh_tag_d   = ShTagW'({sh_tag_q, req_tag});

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    credits_d = credits_q;
    if (fifo_wr) begin
      wr_ptr_d = wr_ptr_q + PtrBits'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrBits'(1);
    end
    // A credit covers a request from acceptance until its result leaves the FIFO.
    case ({accept, pop})
      2'b10:   credits_d = credits_q - CredW'(1);
      2'b01:   credits_d = credits_q + CredW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_valid_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      credits_q  <= CredW'(DEPTH);
    end else begin
      sh_valid_q <= sh_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      credits_q  <= credits_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_tag_q <= sh_tag_d;
    if (fifo_wr && !rst) begin
      mem_r[wr_ptr_q[PtrW-1:0]]   <= fpu_r;
      mem_tag[wr_ptr_q[PtrW-1:0]] <= sh_tag_last;
    end
  end

  assign rsp_r   = rsp_valid ? mem_r[rd_ptr_q[PtrW-1:0]]   : '0;
  assign rsp_tag = rsp_valid ? mem_tag[rd_ptr_q[PtrW-1:0]] : '0;

  assign head_exp  = rsp_r[WIDTH-2 -: 8];
  assign head_mant = rsp_r[WIDTH-10:0];
  assign head_nan  = (head_exp == 8'hFF) && (head_mant != '0);
  assign head_inf  = (head_exp == 8'hFF) && (head_mant == '0);
  assign head_zero = (rsp_r[WIDTH-2:0] == '0);
  assign head_sign = rsp_r[WIDTH-1];

  // Gated so an empty FIFO (rsp_r forced to 0) does not report zero.
  assign rsp_flags = rsp_valid ? {head_nan, head_inf, head_zero, head_sign} : 4'b0000;

endmodule
